game_state_ctrl: RTL and testbench

Frame-synchronous game-state controller that sits directly upstream of the colour mapper. It produces the `Pause` and `endGame` overlay controls that the colour mapper consumes, plus a physics run-enable, a life count and a play-frame counter. Raw key levels and ball-miss events are sampled and acted on only at the start-of-frame strobe, so the overlays never change mid-frame.

---
 rtl/game_state_ctrl.sv | 132 +++++++++++++
 tb/tb_game_state_ctrl.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/game_state_ctrl.sv
// Frame-synchronous game-state controller feeding the colour mapper overlays.
// Keys and ball misses are acted on only at the start-of-frame strobe.
module game_state_ctrl #(
    parameter int LIVES       = 3,
    parameter int LOST_FRAMES = 60
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        frame_sync,
    input  logic        key_pause,
    input  logic        key_restart,
    input  logic        miss,
    output logic        Pause,
    output logic        endGame,
    output logic        run,
    output logic [1:0]  lives,
    output logic [15:0] frame_cnt
);

    localparam logic [1:0] LP_LIVES = 2'(LIVES);
    localparam logic [7:0] LP_LOST  = 8'(LOST_FRAMES);

    typedef enum logic [1:0] {
        S_PLAY,
        S_PAUSED,
        S_LOST,
        S_OVER
    } state_t;

    state_t      r_state;
    logic [1:0]  r_lives;
    logic [15:0] r_frame_cnt;
    logic [7:0]  r_timer;
    logic        r_kp_prev;
    logic        r_kr_prev;
    logic        r_miss_pend;

    state_t      w_state_nxt;
    logic [1:0]  w_lives_nxt;
    logic [15:0] w_cnt_nxt;
    logic [7:0]  w_timer_nxt;
    logic        w_pause_ev;
    logic        w_restart_ev;
    logic        w_miss;

    assign w_pause_ev   = key_pause & ~r_kp_prev;
    assign w_restart_ev = key_restart & ~r_kr_prev;
    assign w_miss       = r_miss_pend | miss;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_state     <= S_PAUSED;
            r_lives     <= LP_LIVES;
            r_frame_cnt <= 16'd0;
            r_timer     <= 8'd0;
            r_kp_prev   <= 1'b1;
            r_kr_prev   <= 1'b1;
            r_miss_pend <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_lives     <= w_lives_nxt;
            r_frame_cnt <= w_cnt_nxt;
            r_timer     <= w_timer_nxt;
            if (frame_sync) begin
                r_kp_prev   <= key_pause;
                r_kr_prev   <= key_restart;
                r_miss_pend <= 1'b0;
            end else if (miss) begin
                r_miss_pend <= 1'b1;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_lives_nxt = r_lives;
        w_cnt_nxt   = r_frame_cnt;
        w_timer_nxt = r_timer;
        if (frame_sync) begin
            if (w_restart_ev) begin
                w_state_nxt = S_PLAY;
                w_lives_nxt = LP_LIVES;
                w_cnt_nxt   = 16'd0;
                w_timer_nxt = 8'd0;
            end else begin
                unique case (r_state)
                    S_PLAY: begin
                        if (w_miss) begin
                            // lives>=1 here; the last life goes straight to OVER
                            if (r_lives <= 2'd1) begin
                                w_lives_nxt = 2'd0;
                                w_state_nxt = S_OVER;
                            end else begin
                                w_lives_nxt = r_lives - 2'd1;
                                w_timer_nxt = LP_LOST;
                                w_state_nxt = S_LOST;
                            end
                        end else if (w_pause_ev) begin
                            w_state_nxt = S_PAUSED;
                        end else if (r_frame_cnt != 16'hFFFF) begin
                            w_cnt_nxt = r_frame_cnt + 16'd1;
                        end
                    end
                    S_PAUSED: begin
                        if (w_pause_ev) w_state_nxt = S_PLAY;
                    end
                    S_LOST: begin
                        if (r_timer <= 8'd1) begin
                            w_timer_nxt = 8'd0;
                            w_state_nxt = S_PLAY;
                        end else begin
                            w_timer_nxt = r_timer - 8'd1;
                        end
                    end
                    S_OVER: begin
                        w_state_nxt = S_OVER;
                    end
                    default: begin
                        w_state_nxt = S_PAUSED;
                    end
                endcase
            end
        end
    end

    assign run       = (r_state == S_PLAY);
    assign Pause     = (r_state == S_PAUSED);
    assign endGame   = (r_state == S_OVER);
    assign lives     = r_lives;
    assign frame_cnt = r_frame_cnt;

endmodule

// File: tb/tb_game_state_ctrl.sv
// Scoreboard bench for game_state_ctrl: a per-frame reference model queues
// expected outputs; a monitor compares them every cycle after each strobe.
module tb_game_state_ctrl;

    localparam int LIVES       = 3;
    localparam int LOST_FRAMES = 60;

    localparam int M_PLAY   = 0;
    localparam int M_PAUSED = 1;
    localparam int M_LOST   = 2;
    localparam int M_OVER   = 3;

    typedef struct {
        int pause;
        int endg;
        int run;
        int lives;
        int cnt;
    } exp_t;

    logic        Clk = 1'b0;
    logic        Reset = 1'b0;
    logic        frame_sync = 1'b0;
    logic        key_pause = 1'b0;
    logic        key_restart = 1'b0;
    logic        miss = 1'b0;
    logic        Pause;
    logic        endGame;
    logic        run;
    logic [1:0]  lives;
    logic [15:0] frame_cnt;

    int checks = 0;
    int errors = 0;

    exp_t q[$];
    exp_t cur;
    bit   cur_ok = 0;
    logic fs_d;

    // reference model state, one step per frame
    int m_st, m_lives, m_cnt, m_timer;
    bit m_kp, m_kr;

    game_state_ctrl #(.LIVES(LIVES), .LOST_FRAMES(LOST_FRAMES)) dut (
        .Clk(Clk),
        .Reset(Reset),
        .frame_sync(frame_sync),
        .key_pause(key_pause),
        .key_restart(key_restart),
        .miss(miss),
        .Pause(Pause),
        .endGame(endGame),
        .run(run),
        .lives(lives),
        .frame_cnt(frame_cnt)
    );

    always #5 Clk = ~Clk;

    always @(posedge Clk or posedge Reset) begin
        if (Reset) fs_d <= 1'b0;
        else       fs_d <= frame_sync;
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    function automatic exp_t reset_exp();
        exp_t e;
        e.pause = 1; e.endg = 0; e.run = 0;
        e.lives = LIVES; e.cnt = 0;
        return e;
    endfunction

    function automatic exp_t model_exp();
        exp_t e;
        e.pause = (m_st == M_PAUSED);
        e.endg  = (m_st == M_OVER);
        e.run   = (m_st == M_PLAY);
        e.lives = m_lives;
        e.cnt   = m_cnt;
        return e;
    endfunction

    task automatic cmp_all(input string tag, input exp_t e);
        chk({tag, ".Pause"}, int'(Pause), e.pause);
        chk({tag, ".endGame"}, int'(endGame), e.endg);
        chk({tag, ".run"}, int'(run), e.run);
        chk({tag, ".lives"}, int'(lives), e.lives);
        chk({tag, ".frame_cnt"}, int'(frame_cnt), e.cnt);
    endtask

    // monitor: outputs must equal the latest expected value on every cycle
    always @(negedge Clk) begin
        if (Reset) begin
            q.delete();
            cur = reset_exp();
            cur_ok = 1;
        end else if (fs_d) begin
            if (q.size() == 0) begin
                chk("queue_underflow", 0, 1);
            end else begin
                cur = q.pop_front();
                cur_ok = 1;
            end
        end
        if (cur_ok) cmp_all("mon", cur);
    end

    task automatic model_reset();
        m_st = M_PAUSED; m_lives = LIVES; m_cnt = 0; m_timer = 0;
        m_kp = 1; m_kr = 1;
    endtask

    task automatic model_frame(input bit kp, input bit kr, input bit missed);
        bit pe, re;
        pe = kp && !m_kp;
        re = kr && !m_kr;
        m_kp = kp;
        m_kr = kr;
        if (re) begin
            m_st = M_PLAY; m_lives = LIVES; m_cnt = 0;
        end else if (m_st == M_PLAY) begin
            if (missed) begin
                m_lives = m_lives - 1;
                if (m_lives == 0) m_st = M_OVER;
                else begin
                    m_st = M_LOST; m_timer = LOST_FRAMES;
                end
            end else if (pe) m_st = M_PAUSED;
            else if (m_cnt < 65535) m_cnt = m_cnt + 1;
        end else if (m_st == M_PAUSED) begin
            if (pe) m_st = M_PLAY;
        end else if (m_st == M_LOST) begin
            m_timer = m_timer - 1;
            if (m_timer == 0) m_st = M_PLAY;
        end
    endtask

    task automatic do_reset();
        @(posedge Clk);
        #3;
        miss = 0; frame_sync = 0;
        Reset = 1;
        #1;
        cmp_all("reset_async", reset_exp());
        model_reset();
        @(posedge Clk);
        #1;
        Reset = 0;
    endtask

    task automatic run_frame(input bit kp, input bit kr, input int gap,
                             input logic [7:0] mmask, input bit mfs);
        bit missed;
        key_pause = kp;
        key_restart = kr;
        missed = mfs;
        for (int i = 0; i < gap; i++) begin
            miss = mmask[i];
            if (mmask[i]) missed = 1;
            @(posedge Clk);
            #1;
            miss = 0;
        end
        miss = mfs;
        frame_sync = 1;
        model_frame(kp, kr, missed);
        q.push_back(model_exp());
        @(posedge Clk);
        #1;
        frame_sync = 0;
        miss = 0;
    endtask

    initial begin
        model_reset();
        #2;
        do_reset();

        // start play: release then press pause
        run_frame(0, 0, 2, 8'h00, 0);
        run_frame(1, 0, 2, 8'h00, 0);
        run_frame(0, 0, 1, 8'h00, 0);
        run_frame(0, 0, 1, 8'h00, 0);
        // held pause key pauses exactly once
        for (int i = 0; i < 5; i++) run_frame(1, 0, 1, 8'h00, 0);
        run_frame(0, 0, 1, 8'h00, 0);
        run_frame(1, 0, 1, 8'h00, 0);
        run_frame(0, 0, 1, 8'h00, 0);
        // mid-frame miss, then LOST freeze with pause presses
        run_frame(0, 0, 3, 8'h02, 0);
        for (int i = 0; i < LOST_FRAMES; i++) run_frame(i[0], 0, 1, 8'h00, 0);
        run_frame(0, 0, 1, 8'h00, 0);
        run_frame(0, 0, 2, 8'h01, 0);
        for (int i = 0; i < LOST_FRAMES; i++) run_frame(0, 0, 1, 8'h00, 0);
        // last life lost on a miss coincident with the strobe
        run_frame(0, 0, 1, 8'h00, 1);
        run_frame(1, 0, 1, 8'h00, 0);
        run_frame(0, 0, 1, 8'h00, 0);
        run_frame(1, 0, 1, 8'h00, 0);
        run_frame(0, 1, 1, 8'h00, 0);
        run_frame(0, 0, 2, 8'h00, 0);
        // three misses plus a pause press in one frame
        run_frame(1, 0, 4, 8'h07, 0);
        for (int i = 0; i < 30; i++) run_frame(0, 0, 1, 8'h00, 0);
        do_reset();

        // saturate frame_cnt with back-to-back strobes
        run_frame(0, 0, 1, 8'h00, 0);
        run_frame(0, 1, 1, 8'h00, 0);
        for (int i = 0; i < 65540; i++) run_frame(0, 0, 0, 8'h00, 0);

        // randomized frames
        for (int f = 0; f < 400; f++) begin
            logic [7:0] mm;
            int gap;
            gap = $urandom_range(0, 5);
            mm = 8'h00;
            for (int b = 0; b < 8; b++)
                if ($urandom_range(0, 7) == 0) mm[b] = 1'b1;
            if ($urandom_range(0, 99) == 0) do_reset();
            run_frame($urandom_range(0, 1) == 1, $urandom_range(0, 24) == 0,
                      gap, mm, $urandom_range(0, 15) == 0);
        end

        repeat (3) @(posedge Clk);
        #1;
        chk("queue_drained", q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
